// File: rtl/bus_initiator.sv
// ============================================================================
// Module   : bus_initiator
// Purpose  : Host-to-register-bus initiator. Each host request is turned into
//            a single-cycle transfer to one of four bidirectional targets that
//            share a tri-state DATA bus. The transfer can be a write, a read or
//            an increment.
// Options  : BUS_TURNAROUND_EN adds one idle TURN cycle after every READ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_initiator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [1:0]              req_sel_i,
    input  logic [DATA_WIDTH-1:0]   req_data_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    rw_o,
    output logic [3:0]              enable_o,
    output logic                    count_o,
    inout  wire  [DATA_WIDTH-1:0]   data_io
);

    localparam int       NUM_TARGETS = 4;
    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_INC    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

`ifdef BUS_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TURN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
`endif

    state_t                   state_q;
    logic [1:0]               op_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     drive_q;
    logic                     req_ready_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic                     rw_q;
    logic [NUM_TARGETS-1:0]   enable_q;
    logic                     count_q;
    logic [NUM_TARGETS-1:0]   sel_onehot_d;

    always_comb begin
        sel_onehot_d            = '0;
        sel_onehot_d[req_sel_i] = 1'b1;
    end

    // The bus is only ever driven while a WRITE transfer is on the wires.
    assign data_io = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= OP_WRITE;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rw_q        <= 1'b1;
            enable_q    <= '0;
            count_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid_i && req_ready_q) begin
                        state_q     <= XFER;
                        op_q        <= req_op_i;
                        wdata_q     <= req_data_i;
                        req_ready_q <= 1'b0;
                        enable_q    <= (req_op_i == OP_RSVD) ? '0 : sel_onehot_d;
                        rw_q        <= (req_op_i == OP_WRITE || req_op_i == OP_INC) ? 1'b0 : 1'b1;
                        count_q     <= (req_op_i == OP_INC);
                        drive_q     <= (req_op_i == OP_WRITE);
                    end
                end
                XFER: begin
                    enable_q <= '0;
                    rw_q     <= 1'b1;
                    count_q  <= 1'b0;
                    drive_q  <= 1'b0;
                    if (op_q == OP_READ) begin
                        rsp_data_q  <= data_io;
                        rsp_valid_q <= 1'b1;
`ifdef BUS_TURNAROUND_EN
                        state_q     <= TURN;
                        req_ready_q <= 1'b0;
`else
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
`endif
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
`ifdef BUS_TURNAROUND_EN
                TURN: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    enable_q    <= '0;
                    rw_q        <= 1'b1;
                    count_q     <= 1'b0;
                    drive_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rw_o        = rw_q;
    assign enable_o    = enable_q;
    assign count_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_initiator.sv
// ============================================================================
// Module   : tb_bus_initiator
// Purpose  : Self-checking bench for bus_initiator, including four behavioural
//            register targets on the shared bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_initiator;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
`ifdef BUS_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tinit;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [1:0]  req_sel_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    logic        rw_o;
    logic [3:0]  enable_o;
    logic        count_o;
    wire  [15:0] bus;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [4];
    logic [15:0] last_rsp;
    logic [15:0] tgt [4];

    always #5 clk = ~clk;

    bus_initiator #(.DATA_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_sel_i(req_sel_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rw_o(rw_o),
        .enable_o(enable_o), .count_o(count_o), .data_io(bus)
    );

    function automatic int tgt_idx(input logic [3:0] e);
        int r = 0;
        for (int i = 0; i < 4; i++) if (e[i]) r = i;
        return r;
    endfunction

    // Register targets: drive when selected with RW=1, load or count when RW=0.
    assign bus = (rw_o && enable_o != 4'b0000) ? tgt[tgt_idx(enable_o)] : 16'hzzzz;

    always @(posedge clk) begin
        if (tinit) begin
            tgt[0] <= 16'h1111; tgt[1] <= 16'h2222; tgt[2] <= 16'h3333; tgt[3] <= 16'h4444;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (enable_o[i] && !rw_o) begin
                    if (count_o) tgt[i] <= tgt[i] + 16'd1;
                    else         tgt[i] <= bus;
                end
            end
        end
    end

    // One full transaction starting at a negedge; ends at the negedge where
    // the initiator is expected to be ready again.
    task automatic do_txn(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] wd);
        int n;
        logic [3:0] exp_en;
        logic [15:0] exp_rd;
        req_valid_i = 1'b1; req_op_i = op; req_sel_i = sel; req_data_i = wd;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL accept_wait: req_ready=%b required 1", req_ready_o);
            req_valid_i = 1'b0; return;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        exp_en = (op == OP_RSVD) ? 4'b0000 : (4'b0001 << sel);
        exp_rd = model[sel];
        checks++;
        if (enable_o !== exp_en) begin errors++; $display("FAIL xfer_enable op=%0d: got %b want %b", op, enable_o, exp_en); end
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL xfer_ready: got %b want 0", req_ready_o); end
        checks++;
        if (count_o !== (op == OP_INC)) begin errors++; $display("FAIL xfer_count op=%0d: got %b want %b", op, count_o, op == OP_INC); end
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL xfer_rsp_valid: got %b want 0", rsp_valid_o); end
        if (op != OP_RSVD) begin
            checks++;
            if (rw_o !== (op == OP_READ)) begin errors++; $display("FAIL xfer_rw op=%0d: got %b want %b", op, rw_o, op == OP_READ); end
        end
        checks++;
        if (op == OP_WRITE) begin
            if (bus !== wd) begin errors++; $display("FAIL xfer_bus_write: got %h want %h", bus, wd); end
        end else if (op == OP_READ) begin
            if (bus !== exp_rd) begin errors++; $display("FAIL xfer_bus_read: got %h want %h", bus, exp_rd); end
        end else begin
            if (bus === wd) begin errors++; $display("FAIL xfer_bus_undriven: got %h want not %h", bus, wd); end
        end
        if (op == OP_WRITE) model[sel] = wd;
        if (op == OP_INC)   model[sel] = model[sel] + 16'd1;
        if (op == OP_READ)  last_rsp = exp_rd;
        @(negedge clk);
        checks++;
        if (enable_o !== 4'b0000 || count_o !== 1'b0 || rw_o !== 1'b1) begin
            errors++; $display("FAIL post_idle_outputs: got en=%b cnt=%b rw=%b want 0000/0/1", enable_o, count_o, rw_o);
        end
        checks++;
        if (rsp_valid_o !== (op == OP_READ)) begin errors++; $display("FAIL post_rsp_valid op=%0d: got %b want %b", op, rsp_valid_o, op == OP_READ); end
        checks++;
        if (rsp_data_o !== last_rsp) begin errors++; $display("FAIL post_rsp_data: got %h want %h", rsp_data_o, last_rsp); end
        checks++;
        if (req_ready_o !== !(op == OP_READ && TURN == 1)) begin
            errors++; $display("FAIL post_ready op=%0d: got %b want %b", op, req_ready_o, !(op == OP_READ && TURN == 1));
        end
        if (op == OP_READ && TURN == 1) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                errors++; $display("FAIL turn_exit: got rsp_valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tinit = 1'b1;
        req_valid_i = 1'b1; req_op_i = OP_WRITE; req_sel_i = 2'd1; req_data_i = 16'hBEEF;
        @(negedge clk); @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_data_o !== 16'h0000 ||
            enable_o !== 4'b0000 || count_o !== 1'b0 || rw_o !== 1'b1) begin
            errors++; $display("FAIL reset_state: got rdy=%b rv=%b rd=%h en=%b cnt=%b rw=%b", req_ready_o, rsp_valid_o, rsp_data_o, enable_o, count_o, rw_o);
        end
        rst = 1'b0; tinit = 1'b0; req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (enable_o !== 4'b0000 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_no_accept: got en=%b ready=%b want 0000/1", enable_o, req_ready_o);
        end
    endtask

    task automatic test_write();
        do_txn(OP_WRITE, 2'd2, 16'hA5C3);
    endtask

    task automatic test_read();
        do_txn(OP_WRITE, 2'd1, 16'h1234);
        do_txn(OP_READ, 2'd1, 16'h5A5A);
        do_txn(OP_READ, 2'd2, 16'h6B6B);
    endtask

    task automatic test_inc();
        do_txn(OP_INC, 2'd3, 16'h0F0F);
        do_txn(OP_READ, 2'd3, 16'h0E0E);
    endtask

    task automatic test_reserved();
        do_txn(OP_RSVD, 2'd0, 16'h7777);
        do_txn(OP_READ, 2'd0, 16'h1357);
    endtask

    task automatic test_back_to_back();
        int k;
        logic [15:0] exp;
        req_valid_i = 1'b1; req_op_i = OP_READ; req_sel_i = 2'd0; req_data_i = 16'h0101;
        @(negedge clk);
        exp = model[0];
        req_op_i = OP_WRITE; req_sel_i = 2'd2; req_data_i = 16'hC0DE;
        k = 0;
        while (!(enable_o == 4'b0100 && rw_o == 1'b0) && k < 8) begin
            @(negedge clk); k++;
            if (k == 1) begin
                checks++;
                if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp) begin
                    errors++; $display("FAIL b2b_rsp: got valid=%b data=%h want 1/%h", rsp_valid_o, rsp_data_o, exp);
                end
            end
        end
        req_valid_i = 1'b0;
        checks++;
        if (k != 2 + TURN) begin errors++; $display("FAIL b2b_latency: got %0d cycles want %0d", k, 2 + TURN); end
        checks++;
        if (bus !== 16'hC0DE) begin errors++; $display("FAIL b2b_bus: got %h want c0de", bus); end
        model[2] = 16'hC0DE;
        last_rsp = exp;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready_o); end
        do_txn(OP_READ, 2'd2, 16'h2468);
    endtask

    task automatic test_reset_abort();
        req_valid_i = 1'b1; req_op_i = OP_READ; req_sel_i = 2'd1; req_data_i = 16'h3C3C;
        @(negedge clk);
        req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rsp = 16'h0000;
        checks++;
        if (enable_o !== 4'b0000 || rsp_valid_o !== 1'b0 || rsp_data_o !== 16'h0000 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL abort_state: got en=%b rv=%b rd=%h rdy=%b want 0000/0/0000/1", enable_o, rsp_valid_o, rsp_data_o, req_ready_o);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL abort_no_rsp: got %b want 0", rsp_valid_o); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [1:0]  sel;
        logic [15:0] wd;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = 2'($urandom_range(0, 3));
            wd  = 16'($urandom_range(1, 16'hFFFF));
            do_txn(op, sel, wd);
        end
        for (int s = 0; s < 4; s++) do_txn(OP_READ, 2'(s), 16'hFFFF);
    endtask

    initial begin
        model[0] = 16'h1111; model[1] = 16'h2222; model[2] = 16'h3333; model[3] = 16'h4444;
        last_rsp = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_inc();
        test_reserved();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the shared DATA bus and request/response data.
REQ-002 Parameter NUM_TARGETS, fixed at 4, number of bidirectional register targets, each with one ENABLE bit.
REQ-003 CLOCK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQ_VALID  input  1  host request present.
REQ-006 REQ_READY  output  1  initiator can accept a request this cycle.
REQ-007 REQ_OP  input  2  00 WRITE, 01 READ, 10 INC, 11 reserved.
REQ-008 REQ_SEL  input  2  target index 0..3.
REQ-009 REQ_DATA  input  DATA_WIDTH  write data for a WRITE op.
REQ-010 RSP_VALID  output  1  one-cycle pulse marking read data valid.
REQ-011 RSP_DATA  output  DATA_WIDTH  captured read data; holds until next READ completes.
REQ-012 RW  output  1  1 = selected target drives DATA; 0 = target loads or counts.
REQ-013 ENABLE  output  NUM_TARGETS  one-hot target select; all zero when idle.
REQ-014 COUNT  output  1  increment strobe to selected target.
REQ-015 DATA  inout  DATA_WIDTH  shared tri-state bus; driven only during WRITE transfer cycles.

Function
REQ-016 The state machine SHALL have states IDLE, XFER and TURN; TURN exists only when BUS_TURNAROUND_EN is defined.
REQ-017 IDLE: REQ_READY=1, ENABLE=0, COUNT=0, RW=1, DATA high-Z.
REQ-018 A request SHALL be accepted on the rising edge where REQ_VALID and REQ_READY are both 1; REQ_OP, REQ_SEL and REQ_DATA SHALL be latched and the state SHALL move to XFER.
REQ-019 XFER lasts exactly one cycle; REQ_READY=0 in XFER and TURN.
REQ-020 XFER WRITE: ENABLE[sel]=1, RW=0, COUNT=0, DATA driven with the latched data.
REQ-021 XFER READ: ENABLE[sel]=1, RW=1, COUNT=0, DATA high-Z; DATA SHALL be sampled into RSP_DATA on the edge ending XFER.
REQ-022 XFER INC: ENABLE[sel]=1, RW=0, COUNT=1, DATA high-Z.
REQ-023 XFER reserved op: ENABLE=0, COUNT=0, DATA high-Z, no response.
REQ-024 RSP_VALID SHALL be 1 for exactly the cycle after a READ XFER and 0 otherwise.
REQ-025 After XFER the state SHALL return to IDLE, except after READ when TURN is compiled in.
REQ-026 Latency: WRITE/INC/reserved occupy 2 cycles (accept to next REQ_READY=1); READ occupies 2 cycles, or 3 with TURN.
REQ-027 ENABLE SHALL never have more than one bit set; DATA SHALL never be driven while RW=1.
REQ-028 REQ_VALID while REQ_READY=0 SHALL be ignored; the host holds the request.

Reset
REQ-029 While RESET=1 at a rising edge: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_DATA=0, ENABLE=0, COUNT=0, RW=1, DATA high-Z.
REQ-030 RESET asserted during XFER or TURN SHALL abort the operation; no RSP_VALID is produced for an aborted READ.
REQ-031 A request presented in the same cycle RESET=1 SHALL NOT be accepted.

Configuration
REQ-032 Macro BUS_TURNAROUND_EN: when defined, READ XFER is followed by one TURN cycle (all bus outputs idle, REQ_READY=0, RSP_VALID=1 in TURN); when undefined, READ returns directly to IDLE, with RSP_VALID=1 in that IDLE cycle.

Verification
REQ-033 Reset then WRITE sel=2 data=16'hA5C3 -> next cycle ENABLE=4'b0100, RW=0, DATA=16'hA5C3; REQ_READY=1 the cycle after.
REQ-034 READ sel=1, target drives 16'h1234 -> ENABLE=4'b0010, RW=1, DATA high-Z from initiator; RSP_VALID pulse with RSP_DATA=16'h1234.
REQ-035 INC sel=3 -> ENABLE=4'b1000, COUNT=1, RW=0 for one cycle, DATA high-Z, no RSP_VALID.
REQ-036 Back-to-back READ then WRITE, REQ_VALID held -> write XFER starts 3 cycles after read accept with BUS_TURNAROUND_EN, 2 cycles without.
REQ-037 RESET pulsed during READ XFER -> next cycle ENABLE=0, RSP_VALID=0, RSP_DATA=0, REQ_READY=1.
REQ-038 Reserved op 2'b11 -> one XFER cycle with ENABLE=0, no RSP_VALID, REQ_READY=1 the cycle after.
